// File: rtl/axi_xbar_pkg.sv
// Shared types and defaults for the crossbar return path.
// Sender index width derives from the default sender count.
package axi_xbar_pkg;

    localparam int SENDER_NUM_DEF = 8;
    localparam int DATA_W_DEF     = 64;
    localparam int DEPTH_DEF      = 8;
    localparam int SRC_W          = $clog2(SENDER_NUM_DEF);

    typedef logic [SRC_W-1:0] src_idx_t;

    // One-hot decode of a sender index; a zero grant yields an all-zero vector.
    function automatic logic [SENDER_NUM_DEF-1:0] src_onehot(input src_idx_t idx, input logic grant);
        logic [SENDER_NUM_DEF-1:0] v;
        v      = '0;
        v[idx] = grant;
        return v;
    endfunction

endpackage

// File: rtl/resp_order_fifo.sv
// Purpose: in-order record of granted sender indices, one entry per outstanding request.
// Latency: push visible at head the cycle after the write; pop advances head next cycle.
// Backpressure: caller must gate push with !full and pop with !empty; no bypass path.
module resp_order_fifo #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_dat,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    // DEPTH is a power of two, so natural pointer overflow is the wrap.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_dat;
    end

    assign head_dat = mem[rd_ptr];
    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);

endmodule

// File: rtl/axi_resp_router.sv
// Purpose: remembers which sender won each request to one slave port and steers its responses back in order.
// Latency: request and response paths are combinational; occupancy and error flag update on the next edge.
// Backpressure: request path blocked while DEPTH requests are outstanding; response beats stall when empty or head sender not ready.
module axi_resp_router
    import axi_xbar_pkg::*;
#(
    parameter int SENDER_NUM = SENDER_NUM_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int DEPTH      = DEPTH_DEF
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          req_valid_i,
    input  logic [$clog2(SENDER_NUM)-1:0] req_src_i,
    output logic                          req_ready_o,
    output logic                          req_valid_o,
    input  logic                          req_ready_i,
    input  logic                          rsp_valid_i,
    input  logic                          rsp_last_i,
    input  logic [DATA_W-1:0]             rsp_data_i,
    output logic                          rsp_ready_o,
    output logic [SENDER_NUM-1:0]         rsp_valid_o,
    input  logic [SENDER_NUM-1:0]         rsp_ready_i,
    output logic [DATA_W-1:0]             rsp_data_o,
    output logic                          rsp_last_o,
    output logic [$clog2(DEPTH):0]        outstanding_o,
    output logic                          err_unexp_o
);

    localparam int SW = $clog2(SENDER_NUM);

    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic [SW-1:0] head;
    logic          head_rdy;

    // Push is gated by the current full flag only: a pop this cycle does not free a slot until the next edge.
    assign req_valid_o = req_valid_i & ~full;
    assign req_ready_o = req_ready_i & ~full;
    assign push        = req_valid_i & req_ready_i & ~full;

    assign head_rdy    = rsp_ready_i[head];
    assign rsp_ready_o = ~empty & head_rdy;
    assign pop         = ~empty & rsp_valid_i & head_rdy & rsp_last_i;

    always_comb begin
        rsp_valid_o = '0;
        if (!empty) rsp_valid_o[head] = rsp_valid_i;
    end

    assign rsp_data_o = rsp_data_i;
    assign rsp_last_o = rsp_last_i;

    resp_order_fifo #(
        .WIDTH (SW),
        .DEPTH (DEPTH)
    ) u_order (
        .clk      (clk),
        .rstn     (rstn),
        .push     (push),
        .push_dat (req_src_i),
        .pop      (pop),
        .head_dat (head),
        .count    (outstanding_o),
        .full     (full),
        .empty    (empty)
    );

    always_ff @(posedge clk) begin
        if (!rstn)                     err_unexp_o <= 1'b0;
        else if (empty && rsp_valid_i) err_unexp_o <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rstn && req_valid_i) assert (int'(req_src_i) < SENDER_NUM);
    end

endmodule

// File: tb/tb_axi_resp_router.sv
// Directed checks of request recording, in-order response steering, full/empty boundaries and reset.
module tb_axi_resp_router;

    logic        clk = 1'b0;
    logic        rstn;
    logic        req_valid_i;
    logic [2:0]  req_src_i;
    logic        req_ready_o;
    logic        req_valid_o;
    logic        req_ready_i;
    logic        rsp_valid_i;
    logic        rsp_last_i;
    logic [63:0] rsp_data_i;
    logic        rsp_ready_o;
    logic [7:0]  rsp_valid_o;
    logic [7:0]  rsp_ready_i;
    logic [63:0] rsp_data_o;
    logic        rsp_last_o;
    logic [3:0]  outstanding_o;
    logic        err_unexp_o;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    axi_resp_router #(.SENDER_NUM(8), .DATA_W(64), .DEPTH(8)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .req_valid_i   (req_valid_i),
        .req_src_i     (req_src_i),
        .req_ready_o   (req_ready_o),
        .req_valid_o   (req_valid_o),
        .req_ready_i   (req_ready_i),
        .rsp_valid_i   (rsp_valid_i),
        .rsp_last_i    (rsp_last_i),
        .rsp_data_i    (rsp_data_i),
        .rsp_ready_o   (rsp_ready_o),
        .rsp_valid_o   (rsp_valid_o),
        .rsp_ready_i   (rsp_ready_i),
        .rsp_data_o    (rsp_data_o),
        .rsp_last_o    (rsp_last_o),
        .outstanding_o (outstanding_o),
        .err_unexp_o   (err_unexp_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic push_one(input logic [2:0] src);
        req_valid_i = 1'b1;
        req_src_i   = src;
        req_ready_i = 1'b1;
        tick();
        req_valid_i = 1'b0;
        req_ready_i = 1'b0;
    endtask

    initial begin
        logic [7:0] exp_oh;
        logic [2:0] cur;
        logic [2:0] nxt;

        rstn        = 1'b0;
        req_valid_i = 1'b0;
        req_src_i   = '0;
        req_ready_i = 1'b0;
        rsp_valid_i = 1'b0;
        rsp_last_i  = 1'b0;
        rsp_data_i  = '0;
        rsp_ready_i = '0;
        tick();
        tick();
        chk("rst_outstanding", outstanding_o, 4'd0);
        chk("rst_err", err_unexp_o, 1'b0);
        chk("rst_rsp_valid", rsp_valid_o, 8'h00);
        chk("rst_req_ready", req_ready_o, 1'b0);
        rstn = 1'b1;
        tick();

        // 1: single request from sender 3, 4-beat burst back
        req_valid_i = 1'b1; req_src_i = 3'd3; req_ready_i = 1'b1;
        settle();
        chk("t1_req_valid_o", req_valid_o, 1'b1);
        chk("t1_req_ready_o", req_ready_o, 1'b1);
        tick();
        req_valid_i = 1'b0; req_ready_i = 1'b0;
        chk("t1_outstanding1", outstanding_o, 4'd1);
        rsp_ready_i = 8'hFF;
        for (int b = 1; b <= 4; b++) begin
            rsp_valid_i = 1'b1;
            rsp_last_i  = (b == 4);
            rsp_data_i  = 64'h11 * b;
            settle();
            chk("t1_rsp_valid_o", rsp_valid_o, 8'h08);
            chk("t1_rsp_ready_o", rsp_ready_o, 1'b1);
            chk("t1_rsp_data_o", rsp_data_o, 64'h11 * b);
            chk("t1_rsp_last_o", rsp_last_o, (b == 4));
            tick();
            if (b < 4) chk("t1_no_early_pop", outstanding_o, 4'd1);
        end
        rsp_valid_i = 1'b0; rsp_last_i = 1'b0;
        chk("t1_outstanding0", outstanding_o, 4'd0);

        // 2: three back-to-back pushes, single-beat responses in order
        req_valid_i = 1'b1; req_ready_i = 1'b1;
        req_src_i = 3'd5; tick();
        req_src_i = 3'd1; tick();
        req_src_i = 3'd7; tick();
        req_valid_i = 1'b0; req_ready_i = 1'b0;
        chk("t2_outstanding3", outstanding_o, 4'd3);
        rsp_valid_i = 1'b1; rsp_last_i = 1'b1;
        settle(); chk("t2_route_5", rsp_valid_o, 8'h20); tick();
        settle(); chk("t2_route_1", rsp_valid_o, 8'h02); tick();
        settle(); chk("t2_route_7", rsp_valid_o, 8'h80); tick();
        rsp_valid_i = 1'b0; rsp_last_i = 1'b0;
        chk("t2_outstanding0", outstanding_o, 4'd0);

        // 3: fill to DEPTH, then pop and request in the same cycle
        for (int i = 0; i < 8; i++) push_one(3'(i));
        chk("t3_outstanding8", outstanding_o, 4'd8);
        req_valid_i = 1'b1; req_src_i = 3'd6; req_ready_i = 1'b1;
        settle();
        chk("t3_full_req_ready", req_ready_o, 1'b0);
        chk("t3_full_req_valid", req_valid_o, 1'b0);
        rsp_valid_i = 1'b1; rsp_last_i = 1'b1;
        settle();
        chk("t3_pop_route_0", rsp_valid_o, 8'h01);
        chk("t3_pop_req_blocked", req_ready_o, 1'b0);
        tick();
        rsp_valid_i = 1'b0; rsp_last_i = 1'b0;
        chk("t3_outstanding7", outstanding_o, 4'd7);
        settle();
        chk("t3_req_ready_after", req_ready_o, 1'b1);
        tick();
        req_valid_i = 1'b0; req_ready_i = 1'b0;
        chk("t3_outstanding8_again", outstanding_o, 4'd8);
        rsp_valid_i = 1'b1; rsp_last_i = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            exp_oh = (i == 8) ? 8'h40 : (8'h01 << i);
            settle();
            chk("t3_drain_route", rsp_valid_o, exp_oh);
            tick();
        end
        rsp_valid_i = 1'b0; rsp_last_i = 1'b0;
        chk("t3_drained", outstanding_o, 4'd0);

        // 4: response while empty raises sticky error
        rsp_valid_i = 1'b1; rsp_last_i = 1'b1;
        settle();
        chk("t4_rsp_ready_o", rsp_ready_o, 1'b0);
        chk("t4_rsp_valid_o", rsp_valid_o, 8'h00);
        chk("t4_err_before_edge", err_unexp_o, 1'b0);
        tick();
        rsp_valid_i = 1'b0; rsp_last_i = 1'b0;
        chk("t4_err_set", err_unexp_o, 1'b1);
        tick(); tick();
        chk("t4_err_sticky", err_unexp_o, 1'b1);
        chk("t4_outstanding0", outstanding_o, 4'd0);

        // 5: head sender 2 stalls mid-burst
        push_one(3'd2);
        rsp_valid_i = 1'b1; rsp_last_i = 1'b0; rsp_data_i = 64'hA5A5; rsp_ready_i = 8'hFF;
        tick();
        rsp_data_i = 64'hBEEF; rsp_ready_i = 8'hFB;
        for (int c = 0; c < 3; c++) begin
            settle();
            chk("t5_stall_rsp_ready", rsp_ready_o, 1'b0);
            chk("t5_stall_rsp_valid", rsp_valid_o, 8'h04);
            chk("t5_stall_data", rsp_data_o, 64'hBEEF);
            tick();
            chk("t5_stall_no_pop", outstanding_o, 4'd1);
        end
        rsp_ready_i = 8'hFF;
        settle();
        chk("t5_resume_ready", rsp_ready_o, 1'b1);
        tick();
        rsp_last_i = 1'b1; rsp_data_i = 64'hC0DE;
        tick();
        rsp_valid_i = 1'b0; rsp_last_i = 1'b0;
        chk("t5_outstanding0", outstanding_o, 4'd0);

        // 6: reset with 4 outstanding mid-burst, then wrap-around traffic
        for (int i = 4; i < 8; i++) push_one(3'(i));
        chk("t6_outstanding4", outstanding_o, 4'd4);
        rsp_valid_i = 1'b1; rsp_last_i = 1'b0;
        tick();
        rsp_valid_i = 1'b0;
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        chk("t6_rst_outstanding", outstanding_o, 4'd0);
        chk("t6_rst_err", err_unexp_o, 1'b0);
        rsp_valid_i = 1'b1;
        settle();
        chk("t6_rst_no_route", rsp_valid_o, 8'h00);
        rsp_valid_i = 1'b0;
        tick();
        cur = 3'd0;
        push_one(cur);
        rsp_valid_i = 1'b1; rsp_last_i = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            nxt = 3'(i * 3);
            req_valid_i = 1'b1; req_ready_i = 1'b1; req_src_i = nxt;
            settle();
            chk("t6_wrap_route", rsp_valid_o, 8'h01 << cur);
            tick();
            chk("t6_wrap_occupancy", outstanding_o, 4'd1);
            cur = nxt;
        end
        req_valid_i = 1'b0; req_ready_i = 1'b0;
        settle();
        chk("t6_final_route", rsp_valid_o, 8'h01 << cur);
        tick();
        rsp_valid_i = 1'b0; rsp_last_i = 1'b0;
        chk("t6_final_empty", outstanding_o, 4'd0);
        chk("t6_no_err", err_unexp_o, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
